l1_memory_arbiter: RTL and testbench

- Sits directly downstream of the per-core L1 instruction cache and the L1 data cache.
- Multiplexes their single-word memory requests onto one shared memory bus port.
- Round-robin arbitration; each granted beat is a registered, single-outstanding transaction.
- Response to each cache is a one-cycle ready pulse with read data, matching the caches' request/ready handshake.

---
 rtl/l1_memory_arbiter_if.sv | 47 ++++
 rtl/l1_memory_arbiter.sv | 131 +++++++++++++
 tb/tb_l1_memory_arbiter.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l1_memory_arbiter_if.sv
// Arbiter connection bundle: I-cache port, D-cache port and the shared memory bus.
// The slave modport is the arbiter's view; master is the surrounding caches and memory.
interface l1_memory_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      instruction_memory_request;
    logic [ADDR_WIDTH-1:0]     instruction_memory_address;
    logic [DATA_WIDTH-1:0]     instruction_memory_read_data;
    logic                      instruction_memory_ready;

    logic                      data_memory_request;
    logic                      data_memory_write_enable;
    logic [ADDR_WIDTH-1:0]     data_memory_address;
    logic [DATA_WIDTH-1:0]     data_memory_write_data;
    logic [DATA_WIDTH/8-1:0]   data_memory_byte_enable;
    logic [DATA_WIDTH-1:0]     data_memory_read_data;
    logic                      data_memory_ready;

    logic                      bus_request;
    logic                      bus_write_enable;
    logic [ADDR_WIDTH-1:0]     bus_address;
    logic [DATA_WIDTH-1:0]     bus_write_data;
    logic [DATA_WIDTH/8-1:0]   bus_byte_enable;
    logic [DATA_WIDTH-1:0]     bus_read_data;
    logic                      bus_ready;

    modport master (
        output instruction_memory_request, instruction_memory_address,
        input  instruction_memory_read_data, instruction_memory_ready,
        output data_memory_request, data_memory_write_enable, data_memory_address,
        output data_memory_write_data, data_memory_byte_enable,
        input  data_memory_read_data, data_memory_ready,
        input  bus_request, bus_write_enable, bus_address, bus_write_data, bus_byte_enable,
        output bus_read_data, bus_ready
    );

    modport slave (
        input  instruction_memory_request, instruction_memory_address,
        output instruction_memory_read_data, instruction_memory_ready,
        input  data_memory_request, data_memory_write_enable, data_memory_address,
        input  data_memory_write_data, data_memory_byte_enable,
        output data_memory_read_data, data_memory_ready,
        output bus_request, bus_write_enable, bus_address, bus_write_data, bus_byte_enable,
        input  bus_read_data, bus_ready
    );
endinterface

// File: rtl/l1_memory_arbiter.sv
// Round-robin arbiter merging L1 I-cache and D-cache single-word requests onto one
// registered memory bus port; one outstanding beat, IDLE -> BUSY -> RESP per beat.
module l1_memory_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter bit RESET_PRIORITY = 1'b0
) (
    input logic                clk,
    input logic                rst,
    l1_memory_arbiter_if.slave mem
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state_reg, state_next;
    // 1 = data side; also identifies the side owning the beat in flight
    logic                  last_grant_reg, last_grant_next;
    logic                  pick_data;

    logic                  bus_request_reg, bus_request_next;
    logic                  bus_write_enable_reg, bus_write_enable_next;
    logic [ADDR_WIDTH-1:0] bus_address_reg, bus_address_next;
    logic [DATA_WIDTH-1:0] bus_write_data_reg, bus_write_data_next;
    logic [BE_WIDTH-1:0]   bus_byte_enable_reg, bus_byte_enable_next;

    logic                  instruction_ready_reg, instruction_ready_next;
    logic                  data_ready_reg, data_ready_next;
    logic [DATA_WIDTH-1:0] instruction_read_data_reg, instruction_read_data_next;
    logic [DATA_WIDTH-1:0] data_read_data_reg, data_read_data_next;

    // Data wins when it is alone, or when both contend and instruction went last
    assign pick_data = mem.data_memory_request &&
                       (!mem.instruction_memory_request || !last_grant_reg);

    always_comb begin
        state_next                 = state_reg;
        last_grant_next            = last_grant_reg;
        bus_request_next           = bus_request_reg;
        bus_write_enable_next      = bus_write_enable_reg;
        bus_address_next           = bus_address_reg;
        bus_write_data_next        = bus_write_data_reg;
        bus_byte_enable_next       = bus_byte_enable_reg;
        instruction_ready_next     = 1'b0;
        data_ready_next            = 1'b0;
        instruction_read_data_next = '0;
        data_read_data_next        = '0;

        case (state_reg)
            IDLE: begin
                if (mem.instruction_memory_request || mem.data_memory_request) begin
                    last_grant_next  = pick_data;
                    bus_request_next = 1'b1;
                    state_next       = BUSY;
                    if (pick_data) begin
                        bus_write_enable_next = mem.data_memory_write_enable;
                        bus_address_next      = mem.data_memory_address;
                        bus_write_data_next   = mem.data_memory_write_data;
                        bus_byte_enable_next  = mem.data_memory_byte_enable;
                    end else begin
                        bus_write_enable_next = 1'b0;
                        bus_address_next      = mem.instruction_memory_address;
                        bus_write_data_next   = '0;
                        bus_byte_enable_next  = '0;
                    end
                end
            end
            BUSY: begin
                if (mem.bus_ready) begin
                    bus_request_next = 1'b0;
                    state_next       = RESP;
                    if (last_grant_reg) begin
                        data_ready_next     = 1'b1;
                        data_read_data_next = mem.bus_read_data;
                    end else begin
                        instruction_ready_next     = 1'b1;
                        instruction_read_data_next = mem.bus_read_data;
                    end
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg                 <= IDLE;
            last_grant_reg            <= !RESET_PRIORITY;
            bus_request_reg           <= 1'b0;
            bus_write_enable_reg      <= 1'b0;
            bus_address_reg           <= '0;
            bus_write_data_reg        <= '0;
            bus_byte_enable_reg       <= '0;
            instruction_ready_reg     <= 1'b0;
            data_ready_reg            <= 1'b0;
            instruction_read_data_reg <= '0;
            data_read_data_reg        <= '0;
        end else begin
            state_reg                 <= state_next;
            last_grant_reg            <= last_grant_next;
            bus_request_reg           <= bus_request_next;
            bus_write_enable_reg      <= bus_write_enable_next;
            bus_address_reg           <= bus_address_next;
            bus_write_data_reg        <= bus_write_data_next;
            bus_byte_enable_reg       <= bus_byte_enable_next;
            instruction_ready_reg     <= instruction_ready_next;
            data_ready_reg            <= data_ready_next;
            instruction_read_data_reg <= instruction_read_data_next;
            data_read_data_reg        <= data_read_data_next;
        end
    end

    assign mem.bus_request                  = bus_request_reg;
    assign mem.bus_write_enable             = bus_write_enable_reg;
    assign mem.bus_address                  = bus_address_reg;
    assign mem.bus_write_data               = bus_write_data_reg;
    assign mem.bus_byte_enable              = bus_byte_enable_reg;
    assign mem.instruction_memory_ready     = instruction_ready_reg;
    assign mem.instruction_memory_read_data = instruction_read_data_reg;
    assign mem.data_memory_ready            = data_ready_reg;
    assign mem.data_memory_read_data        = data_read_data_reg;
endmodule

// File: tb/tb_l1_memory_arbiter.sv
// Scoreboard bench for l1_memory_arbiter: directed cache traffic, a memory responder
// checking bus beats in grant order, and a monitor checking each ready pulse.
module tb_l1_memory_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   mem_ready_cyc = 0;
    int   i_pulse_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    l1_memory_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_if ();

    l1_memory_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .RESET_PRIORITY(1'b0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mem(mem_if)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
        int          waits;
    } bus_txn_t;

    typedef struct {
        logic        side;   // 1 = data
        logic [31:0] data;
    } resp_t;

    bus_txn_t bus_q[$];
    resp_t    resp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_txn(input logic side, input logic [31:0] addr, input logic we,
                              input logic [31:0] wdata, input logic [3:0] be,
                              input logic [31:0] rdata, input int waits, input bit respond);
        bus_txn_t t;
        resp_t    r;
        t.addr = addr; t.we = we; t.wdata = wdata; t.be = be; t.rdata = rdata; t.waits = waits;
        bus_q.push_back(t);
        if (respond) begin
            r.side = side; r.data = rdata;
            resp_q.push_back(r);
        end
    endtask

    // Memory responder: checks every bus beat (and its stability across wait states)
    initial begin
        bus_txn_t cur;
        bit       active;
        int       wcnt;
        active = 1'b0;
        wcnt = 0;
        cur.addr = '0; cur.we = 1'b0; cur.wdata = '0; cur.be = '0; cur.rdata = '0; cur.waits = 0;
        mem_if.bus_ready = 1'b0;
        mem_if.bus_read_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                active = 1'b0;
                mem_if.bus_ready = 1'b0;
                mem_if.bus_read_data = '0;
            end else if (mem_if.bus_request) begin
                if (!active) begin
                    active = 1'b1;
                    wcnt = 0;
                    if (bus_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL bus_unexpected: got addr %h expected no beat", mem_if.bus_address);
                    end else begin
                        cur = bus_q.pop_front();
                    end
                end
                check("bus_address", mem_if.bus_address, cur.addr);
                check("bus_write_enable", 32'(mem_if.bus_write_enable), 32'(cur.we));
                check("bus_write_data", mem_if.bus_write_data, cur.wdata);
                check("bus_byte_enable", 32'(mem_if.bus_byte_enable), 32'(cur.be));
                if (wcnt >= cur.waits) begin
                    mem_if.bus_ready = 1'b1;
                    mem_if.bus_read_data = cur.rdata;
                    mem_ready_cyc = cyc;
                end else begin
                    mem_if.bus_ready = 1'b0;
                    mem_if.bus_read_data = 32'hBAD0_0000 + 32'(wcnt);
                    wcnt++;
                end
            end else begin
                active = 1'b0;
                mem_if.bus_ready = 1'b0;
                mem_if.bus_read_data = '0;
            end
        end
    end

    // Response monitor: pops the scoreboard on every ready pulse
    initial begin
        resp_t e;
        logic  side;
        logic [31:0] data, other;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (mem_if.instruction_memory_ready && mem_if.data_memory_ready) begin
                    total++; bad++;
                    $display("FAIL both_ready: got 11 expected one-hot");
                end else if (mem_if.instruction_memory_ready || mem_if.data_memory_ready) begin
                    side  = mem_if.data_memory_ready;
                    data  = side ? mem_if.data_memory_read_data : mem_if.instruction_memory_read_data;
                    other = side ? mem_if.instruction_memory_read_data : mem_if.data_memory_read_data;
                    if (resp_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL ready_unexpected: got side %0d data %h expected none", side, data);
                    end else begin
                        e = resp_q.pop_front();
                        check("resp_side", 32'(side), 32'(e.side));
                        check("resp_data", data, e.data);
                        check("resp_other_zero", other, 32'h0);
                        check("resp_latency", 32'(cyc), 32'(mem_ready_cyc + 1));
                    end
                    if (!side) i_pulse_q.push_back(cyc);
                end else begin
                    check("idle_read_data", mem_if.instruction_memory_read_data | mem_if.data_memory_read_data, 32'h0);
                end
            end
        end
    end

    task automatic i_run(input logic [31:0] base, input int n);
        int t;
        for (int k = 0; k < n; k++) begin
            mem_if.instruction_memory_request = 1'b1;
            mem_if.instruction_memory_address = base + 32'(4 * k);
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!mem_if.instruction_memory_ready && t < 200);
            if (!mem_if.instruction_memory_ready) check("i_handshake_timeout", 32'(mem_if.instruction_memory_ready), 32'h1);
        end
        mem_if.instruction_memory_request = 1'b0;
        mem_if.instruction_memory_address = '0;
    endtask

    task automatic d_run(input logic [31:0] base, input int n, input logic we,
                         input logic [31:0] wdata, input logic [3:0] be);
        int t;
        for (int k = 0; k < n; k++) begin
            mem_if.data_memory_request      = 1'b1;
            mem_if.data_memory_write_enable = we;
            mem_if.data_memory_address      = base + 32'(4 * k);
            mem_if.data_memory_write_data   = wdata + 32'(k);
            mem_if.data_memory_byte_enable  = be;
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!mem_if.data_memory_ready && t < 200);
            if (!mem_if.data_memory_ready) check("d_handshake_timeout", 32'(mem_if.data_memory_ready), 32'h1);
        end
        mem_if.data_memory_request      = 1'b0;
        mem_if.data_memory_write_enable = 1'b0;
        mem_if.data_memory_address      = '0;
        mem_if.data_memory_write_data   = '0;
        mem_if.data_memory_byte_enable  = '0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int t;
        rst = 1'b1;
        mem_if.instruction_memory_request = 1'b0;
        mem_if.instruction_memory_address = '0;
        mem_if.data_memory_request = 1'b0;
        mem_if.data_memory_write_enable = 1'b0;
        mem_if.data_memory_address = '0;
        mem_if.data_memory_write_data = '0;
        mem_if.data_memory_byte_enable = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_bus_request", 32'(mem_if.bus_request), 32'h0);
        check("reset_bus_write_enable", 32'(mem_if.bus_write_enable), 32'h0);
        check("reset_bus_address", mem_if.bus_address, 32'h0);
        check("reset_bus_write_data", mem_if.bus_write_data, 32'h0);
        check("reset_bus_byte_enable", 32'(mem_if.bus_byte_enable), 32'h0);
        check("reset_ready", 32'({mem_if.instruction_memory_ready, mem_if.data_memory_ready}), 32'h0);
        #1 rst = 1'b0;
        @(negedge clk);

        // Single instruction read
        expect_txn(1'b0, 32'h0000_1000, 1'b0, 32'h0, 4'h0, 32'hDEAD_BEEF, 0, 1'b1);
        i_run(32'h0000_1000, 1);
        repeat (3) @(negedge clk);

        // Data write with partial strobes
        expect_txn(1'b1, 32'h0000_2004, 1'b1, 32'h1234_5678, 4'b0011, 32'h0BAD_F00D, 0, 1'b1);
        d_run(32'h0000_2004, 1, 1'b1, 32'h1234_5678, 4'b0011);
        repeat (3) @(negedge clk);

        // Contention straight after reset: I first, then strict alternation
        do_reset();
        for (int k = 0; k < 4; k++) begin
            expect_txn(1'b0, 32'h100 + 32'(4 * k), 1'b0, 32'h0, 4'h0, 32'h1111_0000 + 32'(k), k % 2, 1'b1);
            expect_txn(1'b1, 32'h3000 + 32'(4 * k), 1'b1, 32'hA000_0000 + 32'(k), 4'hF, 32'h2222_0000 + 32'(k), k % 3, 1'b1);
        end
        fork
            i_run(32'h100, 4);
            d_run(32'h3000, 4, 1'b1, 32'hA000_0000, 4'hF);
        join
        repeat (3) @(negedge clk);

        // Five memory wait states on a data read
        expect_txn(1'b1, 32'h0000_4000, 1'b0, 32'h0, 4'h0, 32'hCAFE_F00D, 5, 1'b1);
        d_run(32'h0000_4000, 1, 1'b0, 32'h0, 4'h0);
        repeat (3) @(negedge clk);

        // Reset while BUSY: beat abandoned, no ready pulse
        expect_txn(1'b0, 32'h0000_5000, 1'b0, 32'h0, 4'h0, 32'h5555_5555, 50, 1'b0);
        mem_if.instruction_memory_request = 1'b1;
        mem_if.instruction_memory_address = 32'h0000_5000;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!mem_if.bus_request && t < 50);
        check("rst_busy_reached", 32'(mem_if.bus_request), 32'h1);
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        mem_if.instruction_memory_request = 1'b0;
        mem_if.instruction_memory_address = '0;
        @(posedge clk);
        #1;
        check("rst_bus_request_cleared", 32'(mem_if.bus_request), 32'h0);
        check("rst_no_ready", 32'({mem_if.instruction_memory_ready, mem_if.data_memory_ready}), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // After reset, contested request goes to instruction side first
        expect_txn(1'b0, 32'h0000_0600, 1'b0, 32'h0, 4'h0, 32'h6666_0000, 0, 1'b1);
        expect_txn(1'b1, 32'h0000_0700, 1'b0, 32'h0, 4'h0, 32'h7777_0000, 0, 1'b1);
        fork
            i_run(32'h0000_0600, 1);
            d_run(32'h0000_0700, 1, 1'b0, 32'h0, 4'h0);
        join
        repeat (3) @(negedge clk);

        // Back-to-back instruction beats with memory always ready
        i_pulse_q.delete();
        for (int k = 0; k < 4; k++)
            expect_txn(1'b0, 32'h0000_8000 + 32'(4 * k), 1'b0, 32'h0, 4'h0, 32'h8888_0000 + 32'(k), 0, 1'b1);
        i_run(32'h0000_8000, 4);
        repeat (3) @(negedge clk);
        check("throughput_count", 32'(i_pulse_q.size()), 32'd4);
        for (int k = 1; k < i_pulse_q.size(); k++)
            check("throughput_spacing", 32'(i_pulse_q[k] - i_pulse_q[k-1]), 32'd3);

        check("scoreboard_resp_empty", 32'(resp_q.size()), 32'd0);
        check("scoreboard_bus_empty", 32'(bus_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "watchdog expired");
    end
endmodule
